// File: rtl/cpu64_l2_mshr_file.sv
// L2 miss-status holding register file: tracks outstanding line misses
// and the per-core probe acknowledgements each one still waits for.
module cpu64_l2_mshr_file #(
    parameter int ENTRIES  = 4,
    parameter int ADDR_W   = 64,
    parameter int SOURCE_W = 6,
    parameter int TYPE_W   = 3,
    parameter int CORES    = 4,
    parameter int LINE_OFF = 6,
    localparam int IW = (ENTRIES > 1) ? $clog2(ENTRIES) : 1,
    localparam int CW = (CORES > 1) ? $clog2(CORES) : 1
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                alloc_valid_i,
    output logic                alloc_ready_o,
    input  logic [ADDR_W-1:0]   alloc_addr_i,
    input  logic [SOURCE_W-1:0] alloc_source_i,
    input  logic [TYPE_W-1:0]   alloc_type_i,
    output logic [IW-1:0]       alloc_id_o,
    output logic                conflict_o,
    input  logic                set_probes_i,
    input  logic [IW-1:0]       set_probes_id_i,
    input  logic [CORES-1:0]    probes_mask_i,
    input  logic                probe_ack_i,
    input  logic [ADDR_W-1:0]   probe_ack_addr_i,
    input  logic [CW-1:0]       probe_ack_core_i,
    input  logic                dealloc_i,
    input  logic [IW-1:0]       dealloc_id_i,
    input  logic [IW-1:0]       lookup_id_i,
    output logic [ADDR_W-1:0]   lookup_addr_o,
    output logic [SOURCE_W-1:0] lookup_source_o,
    output logic [TYPE_W-1:0]   lookup_type_o,
    output logic [CORES-1:0]    lookup_pending_o,
    output logic [ENTRIES-1:0]  valid_o,
    output logic [ENTRIES-1:0]  probes_done_o,
    output logic [IW:0]         count_o,
    output logic                full_o,
    output logic                empty_o,
    output logic                stray_ack_o
);

    typedef enum logic [1:0] {FREE, ACTIVE, PROBE_WAIT, PROBE_DONE} state_e;

    state_e              st_q   [ENTRIES];
    state_e              st_d   [ENTRIES];
    logic [ADDR_W-1:0]   addr_q [ENTRIES];
    logic [ADDR_W-1:0]   addr_d [ENTRIES];
    logic [SOURCE_W-1:0] src_q  [ENTRIES];
    logic [SOURCE_W-1:0] src_d  [ENTRIES];
    logic [TYPE_W-1:0]   typ_q  [ENTRIES];
    logic [TYPE_W-1:0]   typ_d  [ENTRIES];
    logic [CORES-1:0]    pend_q [ENTRIES];
    logic [CORES-1:0]    pend_d [ENTRIES];
    logic                stray_q, stray_d;

    logic [ENTRIES-1:0]  sp_hit, ack_hit;
    logic [CORES-1:0]    ack_bit;
    logic                fire;

    always_comb begin
        conflict_o    = 1'b0;
        alloc_id_o    = '0;
        count_o       = '0;
        valid_o       = '0;
        probes_done_o = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            valid_o[i]       = (st_q[i] != FREE);
            probes_done_o[i] = (st_q[i] == PROBE_DONE);
            if (st_q[i] == FREE) alloc_id_o = IW'(i);
            if (valid_o[i] && addr_q[i][ADDR_W-1:LINE_OFF] ==
                alloc_addr_i[ADDR_W-1:LINE_OFF])
                conflict_o = 1'b1;
            count_o = count_o + {{IW{1'b0}}, valid_o[i]};
        end
    end

    assign full_o        = (count_o == (IW + 1)'(ENTRIES));
    assign empty_o       = (count_o == '0);
    assign alloc_ready_o = !full_o && !conflict_o;
    assign fire          = alloc_valid_i && alloc_ready_o;
    assign ack_bit       = CORES'(1) << probe_ack_core_i;
    assign stray_ack_o   = stray_q;

    assign lookup_addr_o    = addr_q[lookup_id_i];
    assign lookup_source_o  = src_q[lookup_id_i];
    assign lookup_type_o    = typ_q[lookup_id_i];
    assign lookup_pending_o = pend_q[lookup_id_i];

    // An ack may land on an entry in the same cycle its probes are issued
    always_comb begin
        sp_hit  = '0;
        ack_hit = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            sp_hit[i] = set_probes_i && set_probes_id_i == IW'(i) &&
                        st_q[i] == ACTIVE;
            ack_hit[i] = probe_ack_i &&
                         addr_q[i][ADDR_W-1:LINE_OFF] ==
                         probe_ack_addr_i[ADDR_W-1:LINE_OFF] &&
                         (st_q[i] == PROBE_WAIT || sp_hit[i]);
        end
    end

    always_comb begin
        logic [CORES-1:0] p;
        stray_d = probe_ack_i;
        p       = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            st_d[i]   = st_q[i];
            addr_d[i] = addr_q[i];
            src_d[i]  = src_q[i];
            typ_d[i]  = typ_q[i];
            pend_d[i] = pend_q[i];
            p = sp_hit[i] ? probes_mask_i : pend_q[i];
            if (ack_hit[i] && |(p & ack_bit)) stray_d = 1'b0;
            if (ack_hit[i]) p = p & ~ack_bit;
            if (fire && alloc_id_o == IW'(i)) begin
                st_d[i]   = ACTIVE;
                addr_d[i] = alloc_addr_i;
                src_d[i]  = alloc_source_i;
                typ_d[i]  = alloc_type_i;
                pend_d[i] = '0;
            end else if (sp_hit[i] || ack_hit[i]) begin
                pend_d[i] = p;
                st_d[i]   = (p == '0) ? PROBE_DONE : PROBE_WAIT;
            end
            if (dealloc_i && dealloc_id_i == IW'(i) && st_q[i] != FREE) begin
                st_d[i]   = FREE;
                pend_d[i] = '0;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stray_q <= 1'b0;
            for (int i = 0; i < ENTRIES; i++) begin
                st_q[i]   <= FREE;
                addr_q[i] <= '0;
                src_q[i]  <= '0;
                typ_q[i]  <= '0;
                pend_q[i] <= '0;
            end
        end else begin
            stray_q <= stray_d;
            for (int i = 0; i < ENTRIES; i++) begin
                st_q[i]   <= st_d[i];
                addr_q[i] <= addr_d[i];
                src_q[i]  <= src_d[i];
                typ_q[i]  <= typ_d[i];
                pend_q[i] <= pend_d[i];
            end
        end
    end

endmodule

// File: doc/cpu64_l2_mshr_file.md
CPU64_L2_MSHR_FILE -- requirements
Module: cpu64_l2_mshr_file

Interface
REQ-001 SHALL have parameters: ENTRIES, default 4, number of MSHR entries (power of two, 2..16); ADDR_W, default 64, address width; SOURCE_W, default 6, requester source width; TYPE_W, default 3, request opcode width; CORES, default 4, probe targets; LINE_OFF, default 6, line-offset bits ignored in address compares.
REQ-002 SHALL have these ports, in order:
- clk_i  in  1  sole clock.
- rst_ni  in  1  asynchronous active-low reset.
- alloc_valid_i / alloc_ready_o  in/out  1  allocation handshake.
- alloc_addr_i / alloc_source_i / alloc_type_i  in  ADDR_W / SOURCE_W / TYPE_W  request fields.
- alloc_id_o  out  log2(ENTRIES)  entry index granted on this cycle.
- conflict_o  out  1  alloc_addr_i line matches a live entry.
- set_probes_i  in  1  load probe mask.
- set_probes_id_i  in  log2(ENTRIES)  target entry.
- probes_mask_i  in  CORES  cores probed.
- probe_ack_i  in  1  ProbeAck strobe.
- probe_ack_addr_i  in  ADDR_W  ProbeAck address.
- probe_ack_core_i  in  log2(CORES)  acking core.
- dealloc_i / dealloc_id_i  in  1 / log2(ENTRIES)  free an entry.
- lookup_id_i  in  log2(ENTRIES)  read-port index.
- lookup_addr_o / lookup_source_o / lookup_type_o / lookup_pending_o  out  ADDR_W / SOURCE_W / TYPE_W / CORES  fields of the entry at lookup_id_i.
- valid_o / probes_done_o  out  ENTRIES  per-entry status.
- count_o  out  log2(ENTRIES)+1  live entry count.
- full_o / empty_o  out  1  occupancy flags.
- stray_ack_o  out  1  registered pulse for an unmatched ProbeAck.

Function
REQ-003 Each entry SHALL hold its state (FREE, ACTIVE, PROBE_WAIT, PROBE_DONE), addr, source, type and pending mask [CORES].
REQ-004 Line match SHALL compare addr[ADDR_W-1:LINE_OFF] only, against entries not FREE.
REQ-005 conflict_o SHALL be combinational: alloc_addr_i line matches any live entry.
REQ-006 alloc_ready_o SHALL be combinational: !full_o && !conflict_o.
REQ-007 Allocation SHALL fire on alloc_valid_i && alloc_ready_o.
REQ-008 On fire, the lowest-index FREE entry (per registered state) SHALL capture the fields, clear pending and enter ACTIVE on the next edge.
REQ-009 alloc_id_o SHALL show the lowest FREE index combinationally, and SHALL be 0 when full.
REQ-010 set_probes_i SHALL act only on an ACTIVE entry: a non-zero mask loads pending and enters PROBE_WAIT; a zero mask enters PROBE_DONE.
REQ-011 set_probes_i on an entry in any other state SHALL be ignored.
REQ-012 probe_ack_i SHALL clear pending[probe_ack_core_i] in the PROBE_WAIT entry whose line matches probe_ack_addr_i.
REQ-013 When the cleared bit is the last set bit, that entry SHALL enter PROBE_DONE on the same edge.
REQ-014 An ack that matches no PROBE_WAIT entry, or whose core bit is already 0, SHALL change no state and SHALL assert stray_ack_o for exactly the next cycle.
REQ-015 When set_probes_i and a matching probe_ack_i target the same entry in one cycle, the result SHALL be pending = mask & ~ack_bit, with the state transition evaluated on that result.
REQ-016 dealloc_i SHALL move the entry at dealloc_id_i to FREE and clear its pending mask; dealloc of a FREE entry SHALL be a no-op.
REQ-017 An entry freed in cycle N SHALL NOT be allocatable or conflict-free until cycle N+1.
REQ-018 Dealloc and alloc in the same cycle SHALL both take effect on the edge, and count_o SHALL remain unchanged.
REQ-019 Dealloc SHALL take priority over set_probes_i and probe_ack_i to the same entry in the same cycle.
REQ-020 valid_o[i] SHALL be 1 when entry i is not FREE.
REQ-021 probes_done_o[i] SHALL be 1 when entry i is in PROBE_DONE.
REQ-022 count_o SHALL equal popcount(valid_o); full_o SHALL be count_o == ENTRIES; empty_o SHALL be count_o == 0. All three SHALL be registered-state derived.
REQ-023 The lookup outputs SHALL be a combinational read of entry lookup_id_i and SHALL be driven regardless of whether that entry is valid.

Reset
REQ-024 While rst_ni is low, all entries SHALL be FREE with zeroed fields, and stray_ack_o SHALL be 0.
REQ-025 Outputs under reset SHALL be: valid_o=0, probes_done_o=0, count_o=0, empty_o=1, full_o=0, alloc_ready_o=!alloc-conflict (i.e. 1), alloc_id_o=0.
REQ-026 Reset asserted mid-operation SHALL discard all entries and pending probes immediately, without waiting for a clock edge.

Verification
REQ-027 Four allocs to 0x1000, 0x2040, 0x3080, 0x40C0 -> alloc_id_o = 0,1,2,3; then full_o=1, alloc_ready_o=0, count_o=4.
REQ-028 Alloc 0x1000, then alloc 0x1038 -> conflict_o=1, alloc_ready_o=0; no second entry is created.
REQ-029 Entry 0 set_probes mask 4'b0110, then acks core1 and core2 for 0x1000 -> pending 0110→0100→0000, probes_done_o[0]=1 after the second ack.
REQ-030 Ack for 0x5000 core0 with no live match -> stray_ack_o=1 for one cycle, no state change.
REQ-031 Full file: dealloc 2 and alloc 0x9000 in the same cycle -> alloc refused that cycle; next cycle alloc_id_o=2 and the alloc is accepted.
REQ-032 Reset pulse while entry 1 is in PROBE_WAIT -> valid_o=0 and empty_o=1 immediately; a later ack to that entry's address -> stray_ack_o=1.
